// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one 32-bit read per cycle
// and registers the returned word into the IF/ID bundle.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   freeze              downstream stall: hold IF/ID, issue nothing
//   branch_taken/addr   redirect the PC and squash in-flight/skid words
//   mem_address/read    combinational request to InstructionMemory
//   mem_write(_data)    tied to zero (fetch never writes)
//   mem_read_data       registered ReadData, valid one cycle after a read
//   instruction/pc_out  IF/ID register (pc_out = fetch address + PC_STEP)
//   valid               IF/ID register holds a live instruction
module fetch_stage #(
    parameter int INSTRUCTION_LEN = 32,
    parameter int PC_RESET        = 0,
    parameter int PC_STEP         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [INSTRUCTION_LEN-1:0] branch_addr,
    output logic [INSTRUCTION_LEN-1:0] mem_address,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [INSTRUCTION_LEN-1:0] mem_write_data,
    input  logic [INSTRUCTION_LEN-1:0] mem_read_data,
    output logic [INSTRUCTION_LEN-1:0] instruction,
    output logic [INSTRUCTION_LEN-1:0] pc_out,
    output logic                       valid
);

    localparam int W = INSTRUCTION_LEN;

    localparam logic [W-1:0] STEP    = W'(PC_STEP);
    localparam logic [W-1:0] PC_INIT = W'(PC_RESET);

    typedef enum logic {
        RUN,
        STALL
    } state_e;

    state_e       state_q, state_d;

    logic [W-1:0] pc_q, pc_d;

    logic         inflight_q, inflight_d;
    logic [W-1:0] inflight_pc_q, inflight_pc_d;

    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_instr_q, skid_instr_d;
    logic [W-1:0] skid_pc_q, skid_pc_d;

    logic [W-1:0] instr_q, instr_d;
    logic [W-1:0] pc_out_q, pc_out_d;
    logic         valid_q, valid_d;

    logic         run_go;

    // A fetch goes out only when running and nothing else claims the cycle.
    assign run_go = (state_q == RUN) && !freeze && !branch_taken;

    assign mem_address    = pc_q;
    assign mem_read       = rst && run_go;
    assign mem_write      = 1'b0;
    assign mem_write_data = '0;

    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign valid       = valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        valid_d       = valid_q;

        if (branch_taken) begin
            // Redirect wins over freeze; every queued word is stale.
            pc_d         = branch_addr;
            inflight_d   = 1'b0;
            skid_valid_d = 1'b0;
            valid_d      = 1'b0;
            state_d      = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!freeze) begin
                        pc_d          = pc_q + STEP;
                        inflight_d    = 1'b1;
                        inflight_pc_d = pc_q;
                        if (inflight_q) begin
                            instr_d  = mem_read_data;
                            pc_out_d = inflight_pc_q + STEP;
                            valid_d  = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end else begin
                        // The word returning now would be lost while
                        // IF/ID holds, so park it in the skid entry.
                        state_d    = STALL;
                        inflight_d = 1'b0;
                        if (inflight_q) begin
                            skid_instr_d = mem_read_data;
                            skid_pc_d    = inflight_pc_q + STEP;
                            skid_valid_d = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (!freeze) begin
                        // Drain the skid first; fetch restarts next cycle.
                        state_d = RUN;
                        if (skid_valid_q) begin
                            instr_d      = skid_instr_q;
                            pc_out_d     = skid_pc_q;
                            valid_d      = 1'b1;
                            skid_valid_d = 1'b0;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            pc_q          <= PC_INIT;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            valid_q       <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random freeze/branch/reset
// traffic, checked against a queue-based transaction model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .instruction(instruction),
        .pc_out(pc_out),
        .valid(valid)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'd0:   return 32'hE000_0000;
            32'd4:   return 32'hE3A0_0014;
            32'd8:   return 32'hE3A0_1801;
            32'd12:  return 32'hE093_2004;
            default: return {a[15:0] ^ 16'h5A5A, ~a[31:16]} + 32'h1357_9BDF;
        endcase
    endfunction

    // Instruction memory: registered read.
    always @(posedge clk)
        if (mem_read) mem_read_data <= word_at(mem_address);

    // Reference model: addresses fetched but not yet delivered.
    logic [31:0] pend[$];
    logic [31:0] m_pc;
    bit          m_stalled;
    bit          m_known = 0;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic deliver();
        logic [31:0] a;
        if (pend.size() > 0) begin
            a = pend.pop_front();
            m_instr = word_at(a);
            m_pcout = a + 32'd4;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_known   = 1;
            m_pc      = 32'd0;
            m_stalled = 0;
            pend.delete();
            m_instr = '0;
            m_pcout = '0;
            m_valid = 1'b0;
        end else if (branch_taken) begin
            m_pc = branch_addr;
            pend.delete();
            m_valid   = 1'b0;
            m_stalled = 0;
        end else if (!m_stalled) begin
            if (!freeze) begin
                deliver();
                pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end else begin
                m_stalled = 1;
            end
        end else if (!freeze) begin
            m_stalled = 0;
            deliver();
        end
    endtask

    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba);
        logic exp_rd;
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        #1;
        exp_rd = r && m_known && !m_stalled && !f && !b;
        chk("mem_read", {31'd0, mem_read}, {31'd0, exp_rd});
        if (m_known && r) chk("mem_address", mem_address, m_pc);
        chk("mem_write", {31'd0, mem_write}, 32'd0);
        chk("mem_write_data", mem_write_data, 32'd0);
        model_edge();
        @(posedge clk);
        #1;
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
        chk("instruction", instruction, m_instr);
        chk("pc_out", pc_out, m_pcout);
    endtask

    initial begin
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = '0;
        @(negedge clk);

        // Reset then free-running stream.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // Freeze while fetch of 8 is in flight.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

        // Branch to 16 while fetch of 8 is in flight.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'd16);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Branch+freeze together in STALL with skid full.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h40);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Reset during STALL, then restart from 0.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // PC wrap.
        step(1, 0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, f, b;
            logic [31:0] ba;
            r  = ($urandom_range(99) >= 2);
            f  = ($urandom_range(99) < 25);
            b  = ($urandom_range(99) < 10);
            ba = $urandom;
            if ($urandom_range(3) != 0) ba[1:0] = 2'b00;
            step(r, f, b, ba);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
